// File: rtl/mac_tcdm_responder_if.sv
// Bundled TCDM port group: MP request/response channels carried as packed per-port vectors.
interface mac_tcdm_responder_if #(
  parameter int MP = 4
);
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/mac_tcdm_responder.sv
// Word-interleaved banked TCDM responder: per-bank round-robin grant, one-cycle
// registered response, sticky out-of-range flag and saturating conflict counter.
module mac_tcdm_responder #(
  parameter int MP    = 4,
  parameter int NB    = 4,
  parameter int DEPTH = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [MP-1:0]        gnt_mask_i,
  mac_tcdm_responder_if.slave  tcdm,
  output logic                 err_o,
  output logic [15:0]          conflict_cnt_o
);

  localparam int LNB   = $clog2(NB);
  localparam int BW    = (NB > 1) ? LNB : 1;
  localparam int PW    = (MP > 1) ? $clog2(MP) : 1;
  localparam int WORDS = NB * DEPTH;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [29:0]          word     [MP];
  logic [BW-1:0]        bank     [MP];
  logic [MP-1:0]        in_range;
  logic [PW-1:0]        ptr      [NB];
  logic [NB-1:0]        win_vld;
  logic [PW-1:0]        win_port [NB];
  logic [MP-1:0]        gnt;
  logic [15:0]          nconf;
  logic [31:0]          mem      [WORDS];
  logic [MP-1:0]        rvalid_p1;
  logic [MP-1:0][31:0]  rdata_p1;
  logic [MP-1:0]        unused_addr_lsb;

  // Decode: since row < DEPTH, the flat word index doubles as the storage index.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      word[p]            = tcdm.add[p][31:2];
      bank[p]            = BW'(word[p] & 30'(NB - 1));
      in_range[p]        = (word[p] >> LNB) < 30'(DEPTH);
      unused_addr_lsb[p] = ^tcdm.add[p][1:0];
    end
  end

  always_comb begin
    int idx;
    int ncand;
    gnt   = '0;
    nconf = '0;
    for (int b = 0; b < NB; b++) begin
      win_vld[b]  = 1'b0;
      win_port[b] = '0;
      ncand       = 0;
      for (int k = 0; k < MP; k++) begin
        idx = (int'(ptr[b]) + k) % MP;
        if (tcdm.req[idx] && !gnt_mask_i[idx] && (bank[idx] == BW'(b))) begin
          ncand = ncand + 1;
          if (!win_vld[b]) begin
            win_vld[b]  = 1'b1;
            win_port[b] = PW'(idx);
          end
        end
      end
      if (ncand >= 2) nconf = nconf + 16'd1;
      if (win_vld[b] && !clear_i) gnt[win_port[b]] = 1'b1;
    end
  end

  assign tcdm.gnt = gnt;

  // Stage p1: memory update, response registers and statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      for (int b = 0; b < NB; b++) ptr[b] <= '0;
      rvalid_p1      <= '0;
      rdata_p1       <= '0;
      err_o          <= 1'b0;
      conflict_cnt_o <= '0;
    end else if (clear_i) begin
      for (int b = 0; b < NB; b++) ptr[b] <= '0;
      rvalid_p1      <= '0;
      rdata_p1       <= '0;
      err_o          <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      conflict_cnt_o <= sat_add16(conflict_cnt_o, nconf);
      for (int b = 0; b < NB; b++) begin
        if (win_vld[b]) ptr[b] <= PW'((int'(win_port[b]) + 1) % MP);
      end
      rvalid_p1 <= gnt;
      for (int p = 0; p < MP; p++) begin
        rdata_p1[p] <= '0;
        if (gnt[p]) begin
          if (!in_range[p]) begin
            err_o <= 1'b1;
          end else if (tcdm.wen[p]) begin
            rdata_p1[p] <= mem[word[p][AW-1:0]];
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (tcdm.be[p][i]) mem[word[p][AW-1:0]][8*i +: 8] <= tcdm.data[p][8*i +: 8];
            end
          end
        end
      end
    end
  end

  assign tcdm.r_valid = rvalid_p1;
  assign tcdm.r_data  = rdata_p1;

endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Directed bench for mac_tcdm_responder: access, byte enables, arbitration, mask, error, clear, reset.
module tb_mac_tcdm_responder;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [3:0]  gnt_mask_i;
  logic        err_o;
  logic [15:0] conflict_cnt_o;
  int          total = 0;
  int          bad   = 0;

  mac_tcdm_responder_if #(.MP(4)) tcdm ();

  mac_tcdm_responder #(.MP(4), .NB(4), .DEPTH(256)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .gnt_mask_i     (gnt_mask_i),
    .tcdm           (tcdm),
    .err_o          (err_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    tcdm.req[p]  = 1'b1;
    tcdm.add[p]  = a;
    tcdm.wen[p]  = w;
    tcdm.be[p]   = b;
    tcdm.data[p] = d;
  endtask

  task automatic drop(input int p);
    tcdm.req[p] = 1'b0;
  endtask

  initial begin
    rst_ni     = 1'b0;
    clear_i    = 1'b0;
    gnt_mask_i = '0;
    tcdm.req   = '0;
    tcdm.add   = '0;
    tcdm.wen   = '0;
    tcdm.be    = '0;
    tcdm.data  = '0;
    #3;
    chk("rst_rvalid", 32'(tcdm.r_valid), 32'h0);
    chk("rst_rdata0", tcdm.r_data[0], 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_cnt", 32'(conflict_cnt_o), 32'h0);
    chk("rst_gnt", 32'(tcdm.gnt), 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Single write then read
    set_port(0, 32'h10, 1'b0, 4'hF, 32'hCAFEBABE);
    #1 chk("wr_gnt", 32'(tcdm.gnt), 32'h1);
    tick();
    chk("wr_rvalid", 32'(tcdm.r_valid), 32'h1);
    chk("wr_rdata", tcdm.r_data[0], 32'h0);
    set_port(0, 32'h10, 1'b1, 4'hF, 32'h0);
    #1 chk("rd_gnt", 32'(tcdm.gnt), 32'h1);
    tick();
    chk("rd_rvalid", 32'(tcdm.r_valid), 32'h1);
    chk("rd_rdata", tcdm.r_data[0], 32'hCAFEBABE);

    // Byte enables, plus a marker word at address 0
    set_port(0, 32'h20, 1'b0, 4'hF, 32'h11223344);
    tick();
    set_port(0, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD);
    tick();
    set_port(0, 32'h0, 1'b0, 4'hF, 32'h5A5A5A5A);
    tick();
    set_port(0, 32'h20, 1'b1, 4'hF, 32'h0);
    tick();
    chk("be_rdata", tcdm.r_data[0], 32'h11BB33DD);
    tick();
    chk("b2b_rvalid", 32'(tcdm.r_valid), 32'h1);
    chk("b2b_rdata", tcdm.r_data[0], 32'h11BB33DD);
    drop(0);

    // Mask: port 0 inhibited, port 1 alone on bank 1
    gnt_mask_i = 4'b0001;
    set_port(0, 32'h4, 1'b1, 4'hF, 32'h0);
    set_port(1, 32'h14, 1'b1, 4'hF, 32'h0);
    #1 chk("mask_gnt", 32'(tcdm.gnt), 32'b0010);
    tick();
    chk("mask_rvalid", 32'(tcdm.r_valid), 32'b0010);
    chk("mask_cnt", 32'(conflict_cnt_o), 32'h0);
    drop(1);
    #1 chk("mask_hold_gnt", 32'(tcdm.gnt), 32'h0);
    tick();
    chk("mask_hold_rvalid", 32'(tcdm.r_valid), 32'h0);
    gnt_mask_i = 4'b0000;
    #1 chk("unmask_gnt", 32'(tcdm.gnt), 32'b0001);
    tick();
    chk("unmask_rvalid", 32'(tcdm.r_valid), 32'b0001);
    chk("unmask_rdata", tcdm.r_data[0], 32'h0);
    drop(0);

    // Out-of-range read by port 1 contending with port 2 on bank 0
    set_port(1, 32'h1000, 1'b1, 4'hF, 32'h0);
    set_port(2, 32'h0, 1'b1, 4'hF, 32'h0);
    #1 chk("oor_gnt", 32'(tcdm.gnt), 32'b0010);
    tick();
    chk("oor_rvalid", 32'(tcdm.r_valid), 32'b0010);
    chk("oor_rdata", tcdm.r_data[1], 32'h0);
    chk("oor_err", 32'(err_o), 32'h1);
    chk("oor_cnt", 32'(conflict_cnt_o), 32'h1);
    drop(1);
    #1 chk("oor_next_gnt", 32'(tcdm.gnt), 32'b0100);
    tick();
    chk("oor_next_rdata", tcdm.r_data[2], 32'h5A5A5A5A);
    chk("err_sticky", 32'(err_o), 32'h1);
    drop(2);

    // Clear with a concurrent write that must be suppressed
    set_port(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    clear_i = 1'b1;
    #1 chk("clr_gnt", 32'(tcdm.gnt), 32'h0);
    tick();
    clear_i = 1'b0;
    drop(0);
    chk("clr_err", 32'(err_o), 32'h0);
    chk("clr_cnt", 32'(conflict_cnt_o), 32'h0);
    chk("clr_rvalid", 32'(tcdm.r_valid), 32'h0);

    // Round robin on bank 0 from a cleared pointer
    set_port(0, 32'h0, 1'b1, 4'hF, 32'h0);
    set_port(1, 32'h10, 1'b1, 4'hF, 32'h0);
    set_port(2, 32'h20, 1'b1, 4'hF, 32'h0);
    set_port(3, 32'h30, 1'b1, 4'hF, 32'h0);
    #1 chk("rr0_gnt", 32'(tcdm.gnt), 32'b0001);
    tick();
    chk("rr0_rdata", tcdm.r_data[0], 32'h5A5A5A5A);
    chk("rr0_cnt", 32'(conflict_cnt_o), 32'd1);
    drop(0);
    #1 chk("rr1_gnt", 32'(tcdm.gnt), 32'b0010);
    tick();
    chk("rr1_rdata", tcdm.r_data[1], 32'hCAFEBABE);
    chk("rr1_cnt", 32'(conflict_cnt_o), 32'd2);
    drop(1);
    #1 chk("rr2_gnt", 32'(tcdm.gnt), 32'b0100);
    tick();
    chk("rr2_rdata", tcdm.r_data[2], 32'h11BB33DD);
    chk("rr2_cnt", 32'(conflict_cnt_o), 32'd3);
    drop(2);
    #1 chk("rr3_gnt", 32'(tcdm.gnt), 32'b1000);
    tick();
    chk("rr3_rvalid", 32'(tcdm.r_valid), 32'b1000);
    chk("rr3_rdata", tcdm.r_data[3], 32'h0);
    chk("rr3_cnt", 32'(conflict_cnt_o), 32'd3);
    drop(3);

    // All ports to distinct banks in one cycle
    set_port(0, 32'h0, 1'b1, 4'hF, 32'h0);
    set_port(1, 32'h4, 1'b1, 4'hF, 32'h0);
    set_port(2, 32'h8, 1'b1, 4'hF, 32'h0);
    set_port(3, 32'hC, 1'b1, 4'hF, 32'h0);
    #1 chk("par_gnt", 32'(tcdm.gnt), 32'hF);
    tick();
    chk("par_rvalid", 32'(tcdm.r_valid), 32'hF);
    chk("par_rdata0", tcdm.r_data[0], 32'h5A5A5A5A);
    chk("par_cnt", 32'(conflict_cnt_o), 32'd3);
    for (int p = 0; p < 4; p++) drop(p);

    // Asynchronous reset with a response pending
    set_port(0, 32'h10, 1'b1, 4'hF, 32'h0);
    tick();
    chk("pre_rst_rvalid", 32'(tcdm.r_valid), 32'h1);
    chk("pre_rst_rdata", tcdm.r_data[0], 32'hCAFEBABE);
    drop(0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_rvalid", 32'(tcdm.r_valid), 32'h0);
    chk("arst_rdata", tcdm.r_data[0], 32'h0);
    chk("arst_cnt", 32'(conflict_cnt_o), 32'h0);
    #1 rst_ni = 1'b1;
    set_port(0, 32'h10, 1'b1, 4'hF, 32'h0);
    #1 chk("post_rst_gnt", 32'(tcdm.gnt), 32'h1);
    tick();
    chk("post_rst_rvalid", 32'(tcdm.r_valid), 32'h1);
    chk("post_rst_rdata", tcdm.r_data[0], 32'h0);
    drop(0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_tcdm_responder.md
# mac_tcdm_responder

Multi-port, word-interleaved, banked TCDM memory that answers the master ports driven by the MAC streamer's sources and sink. It sits on the far end of the `hwpe_stream_intf_tcdm` ports and closes the loop in block-level benches and FPGA bring-up without a cluster interconnect. It provides:
- per-bank round-robin arbitration;
- fixed one-cycle response latency;
- a grant-mask input for back-pressure injection;
- sticky error and conflict statistics.

## Interface
- MP, 4, number of TCDM slave ports.
- NB, 4, number of banks; power of two, ≥1.
- DEPTH, 256, 32-bit words per bank; total capacity is NB*DEPTH words.
- clk_i  in  1  clock; all state is on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear of arbitration, response and statistics state. Memory contents are kept.
- gnt_mask_i  in  MP  per-port grant inhibit; 1 = port never granted this cycle.
- tcdm  slave  MP × `hwpe_stream_intf_tcdm`  signals per port:
  - req: in, 1.
  - gnt: out, 1.
  - add: in, 32, byte address.
  - wen: in, 1; 1 = read, 0 = write.
  - be: in, 4.
  - data: in, 32.
  - r_data: out, 32.
  - r_valid: out, 1.
- err_o  out  1  sticky out-of-range access flag.
- conflict_cnt_o  out  16  saturating count of bank conflicts.

## Operation
- Address decode:
  - word = add[31:2]; add[1:0] is ignored.
  - bank = word mod NB.
  - row = word / NB.
  - In range iff row < DEPTH.
- Arbitration (per bank, independent):
  - Candidates are ports with req=1, gnt_mask_i=0 and decoded bank equal to that bank.
  - Grant goes to the first candidate at or after that bank's pointer, searching upward with wrap modulo MP.
  - On a grant, the pointer becomes granted_port+1 (mod MP). It is unchanged when there is no grant.
  - At most one grant per bank per cycle. All MP ports can be granted together if they target distinct banks.
- Conflict counting:
  - For each cycle, conflict_cnt_o increments by the number of banks with ≥2 candidates.
  - It saturates at 16'hFFFF.
  - Masked ports are not candidates.
- Write (wen=0, granted, in range):
  - Each byte i with be[i]=1 takes data[8i+7:8i] at the clock edge.
  - Bytes with be[i]=0 are unchanged.
- Read (wen=1, granted, in range):
  - r_data on the next cycle is the row content before any write in the grant cycle.
  - A read and a write to the same word in one cycle is impossible, because the bank serialises them.
- Out of range (granted):
  - The write is dropped and r_data = 0.
  - err_o sets to 1 and stays 1 until reset or clear_i.
- Ungranted requests have no side effects. The master holds req/add/wen/be/data until gnt, per TCDM rules.

## Timing
- gnt is combinational from req, add, gnt_mask_i and the bank pointers in the same cycle. There is no dependency on r_* outputs.
- r_valid is registered and equals 1 exactly one cycle after each grant, for reads and for writes.
- r_data is registered:
  - read data for reads;
  - 32'h0 for writes and out-of-range reads.
- Back-to-back: a port granted every cycle gets r_valid every cycle. Throughput is 1 access/port/cycle with no conflicts.
- Reset values:
  - gnt follows its combinational function; with all req=0, gnt=0.
  - r_valid=0, r_data=0.
  - All bank pointers=0.
  - err_o=0, conflict_cnt_o=0.
  - All memory words=0.
- clear_i=1 takes priority over same-cycle activity:
  - gnt is forced to 0 on all ports during clear_i.
  - Next cycle: r_valid=0, r_data=0, pointers=0, err_o=0, conflict_cnt_o=0.
  - No memory write occurs in the clear cycle.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately (asynchronously).
  - A pending r_valid is lost.
  - Memory returns to 0.
- Pointer wrap: when the granted port is MP-1, the pointer becomes 0.

## Test plan
- Single write/read:
  - Port 0 writes add=0x10, be=4'hF, data=0xCAFEBABE; gnt is the same cycle and r_valid follows next cycle.
  - Port 0 then reads add=0x10; r_valid the cycle after gnt with r_data=0xCAFEBABE.
- Byte enables: write 0x11223344 to add=0x20, then write be=4'b0101, data=0xAABBCCDD; a read returns 0x11BB33DD.
- Conflict round-robin:
  - Ports 0–3 all read bank 0 (add=0x0, 0x10, 0x20, 0x30 with NB=4), holding req.
  - Grants occur in order 0,1,2,3 over four cycles.
  - conflict_cnt_o = 3 after the cycles with ≥2 candidates: 3 (cycles 0–2).
- Parallel distinct banks: ports 0–3 read add=0x0,0x4,0x8,0xC in one cycle; all gnt=1 that cycle and all r_valid=1 the next cycle.
- Mask and error:
  - gnt_mask_i=4'b0001 with port 0 req → no gnt until the mask drops.
  - Port 1 reads add=NB*DEPTH*4 → gnt, r_data=0, err_o=1 thereafter.
- Clear and reset:
  - clear_i pulsed mid-stream → err_o=0, conflict_cnt_o=0, pointers=0, and previously written data is still readable.
  - rst_ni low mid-stream → r_valid=0 immediately and readback returns 0.
